fsic_wb_dispatch: RTL and testbench
===================================

# fsic_wb_dispatch

Wishbone slave front end for the FSIC user area. It takes the single management-SoC Wishbone slave port and shares it among NT internal register targets (config block, AXI-Lite bridge CSRs, IO-serdes CSRs, user-project CSRs). It decodes one 4 KB window per target, sequences one classic-cycle transaction at a time and bounds each access with a timeout. On a decode miss or timeout it returns an error word and counts the event, so a hung target cannot stall the management core.

## Interface
Parameters:
- NT, 4: number of downstream targets (1..8)
- TIMEOUT, 255: max wait cycles for a target ack (1..255)
- ERR_DATA, 32'hDEAD_BEEF: read data returned on miss or timeout

Ports:
- wb_clk  input  1  sole clock, all logic posedge
- wb_rst_n  input  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low
- wbs_cyc, wbs_stb, wbs_we  input  1 each  upstream Wishbone control
- wbs_adr  input  32  upstream address
- wbs_wdata  input  32  upstream write data
- wbs_sel  input  4  byte enables
- wbs_ack  output  1  upstream ack, one-cycle pulse
- wbs_rdata  output  32  upstream read data, valid with wbs_ack
- t_cyc, t_stb  output  NT each  per-target one-hot cycle/strobe
- t_we  output  1  latched write enable
- t_adr  output  12  latched offset wbs_adr[11:0]
- t_wdata  output  32  latched write data
- t_sel  output  4  latched byte enables
- t_rdata  input  NT*32  target i read data at [32*i+31:32*i]
- t_ack  input  NT  per-target ack
- err_cnt  output  8  saturating count of miss and timeout events
- err_irq  output  1  one-cycle pulse per miss or timeout event

## Operation
- Decode: hit when wbs_adr[31:16]==16'h3000 and wbs_adr[15:12] < NT; target index = wbs_adr[15:12]. Anything else is a miss.
- FSM states:
  - IDLE: on wbs_cyc&wbs_stb, latch adr/wdata/sel/we/index. Hit goes to WAIT; miss goes to RESP with err flag set.
  - WAIT: t_cyc[idx]=t_stb[idx]=1. wait_cnt increments from 0 each cycle.
    - t_ack[idx]=1: latch t_rdata[idx], go to RESP.
    - otherwise wait_cnt==TIMEOUT-1: latch ERR_DATA, set err flag, go to RESP.
    - wbs_cyc=0: abort, drop t_cyc/t_stb, go to IDLE with no ack and no error.
  - RESP: wbs_ack=1 for exactly one cycle with the latched rdata (ERR_DATA on error, including writes). On error, err_irq=1 and err_cnt increments, saturating at 255. Next state is IDLE.
- Writes on error are dropped; no target sees a strobe on a miss.
- t_ack on a non-selected target, or in IDLE/RESP, is ignored.
- If t_ack and timeout occur in the same cycle, the ack wins: no error.
- Ack-and-abort in the same cycle: the abort wins. No upstream ack, data discarded.

## Timing
- Reset values: state IDLE, wbs_ack=0, wbs_rdata=0, t_cyc=t_stb=0, t_we=0, t_adr=0, t_wdata=0, t_sel=0, err_cnt=0, err_irq=0, wait_cnt=0.
- All outputs are registered.
- Strobe sampled at edge N: t_stb is high from N+1. A target acking combinationally at N+1 produces wbs_ack at N+2.
- General hit latency: wbs_ack appears 1 cycle after the t_ack edge. Minimum is 2 cycles after the upstream strobe is sampled.
- Miss: wbs_ack at N+1.
- Timeout with no ack: t_stb high for TIMEOUT cycles, then wbs_ack one cycle later.
- Only one transaction in flight. The upstream strobe is not sampled in WAIT or RESP; the cycle after RESP is IDLE and can accept a new strobe.
- Reset asserted mid-transaction: all outputs clear immediately (asynchronous), no ack is issued.

## Structure
- Shared package fsic_wb_pkg: state encoding (IDLE/WAIT/RESP), base constant 16'h3000, ERR_DATA default, window width 12.
- Sub-module fsic_wb_decode: combinational hit/index from wbs_adr and NT.

## Test plan
- Read target 2, wbs_adr=0x3000_2010, target acks 3 cycles after t_stb with 0x1234_5678 -> t_stb[2] only, t_adr=0x010, wbs_rdata=0x1234_5678, single wbs_ack, err_cnt=0.
- Write wbs_adr=0x3000_0004, data=0xA5A5_0F0F, sel=4'b0011 -> t_we=1, t_wdata/t_sel match, wbs_ack one cycle after t_ack[0].
- Miss, wbs_adr=0x3000_7000 with NT=4 -> no t_stb, wbs_ack at N+1, rdata=0xDEAD_BEEF, err_irq pulse, err_cnt=1.
- Timeout, TIMEOUT=8, target silent -> t_stb high exactly 8 cycles, then wbs_ack with 0xDEAD_BEEF; err_cnt increments. Same-cycle ack at the last cycle -> real data, no error.
- Abort, wbs_cyc dropped in WAIT -> t_cyc cleared next cycle, no wbs_ack, err_cnt unchanged. Next access completes normally.
- Async reset mid-WAIT, plus 300 misses -> outputs zero without a clock edge; err_cnt saturates at 255.

Source files
------------

// File: rtl/fsic_wb_pkg.sv
// Shared constants and state encoding for the FSIC Wishbone dispatcher.
package fsic_wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int unsigned WIN_W  = 12;
    localparam int unsigned PAGE_W = 32 - WIN_W;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned CNT_W  = 8;

    localparam logic [15:0] WB_BASE      = 16'h3000;
    localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

endpackage

// File: rtl/fsic_wb_decode.sv
// Address decode: one 4 KB window per target under the 0x3000_xxxx page.
module fsic_wb_decode
    import fsic_wb_pkg::*;
#(
    parameter int unsigned NT = 4
) (
    input  logic [PAGE_W-1:0] page,
    output logic              hit_c,
    output logic [IDX_W-1:0]  idx_c
);

    assign hit_c = (page[PAGE_W-1 -: 16] == WB_BASE) && (32'(page[3:0]) < NT);
    assign idx_c = page[IDX_W-1:0];

endmodule

// File: rtl/fsic_wb_dispatch.sv
// Wishbone slave front end: routes one classic-cycle access at a time to NT
// register targets, with decode-miss and timeout error responses.
module fsic_wb_dispatch
    import fsic_wb_pkg::*;
#(
    parameter int unsigned NT       = 4,
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = ERR_DATA_DEF
) (
    input  logic               wb_clk,
    input  logic               wb_rst_n,
    input  logic               wbs_cyc,
    input  logic               wbs_stb,
    input  logic               wbs_we,
    input  logic [31:0]        wbs_adr,
    input  logic [31:0]        wbs_wdata,
    input  logic [3:0]         wbs_sel,
    output logic               wbs_ack,
    output logic [31:0]        wbs_rdata,
    output logic [NT-1:0]      t_cyc,
    output logic [NT-1:0]      t_stb,
    output logic               t_we,
    output logic [WIN_W-1:0]   t_adr,
    output logic [31:0]        t_wdata,
    output logic [3:0]         t_sel,
    input  logic [NT*32-1:0]   t_rdata,
    input  logic [NT-1:0]      t_ack,
    output logic [CNT_W-1:0]   err_cnt,
    output logic               err_irq
);

    state_t             state, nxt;
    logic [IDX_W-1:0]   idx_q, dec_idx_c, sel_idx_c;
    logic [CNT_W-1:0]   wait_cnt;
    logic               dec_hit_c, req_c, abort_c, ack_c, tmo_c, resp_err_c;
    logic [31:0]        tgt_rdata_c;

    logic               ack_d, we_d, irq_d;
    logic [31:0]        rdata_d, wdata_d;
    logic [NT-1:0]      strobe_d;
    logic [WIN_W-1:0]   adr_d;
    logic [3:0]         sel_d;
    logic [IDX_W-1:0]   idx_d;
    logic [CNT_W-1:0]   wait_d, err_cnt_d;

    fsic_wb_decode #(.NT(NT)) u_decode (
        .page  (wbs_adr[31:WIN_W]),
        .hit_c (dec_hit_c),
        .idx_c (dec_idx_c)
    );

    assign req_c   = wbs_cyc & wbs_stb;
    assign abort_c = ~wbs_cyc;
    assign tmo_c   = (wait_cnt == CNT_W'(TIMEOUT - 1));

    // Only the latched target's ack and data are visible to the FSM
    always_comb begin
        ack_c       = 1'b0;
        tgt_rdata_c = '0;
        for (int i = 0; i < NT; i++) begin
            if (idx_q == IDX_W'(i)) begin
                ack_c       = t_ack[i];
                tgt_rdata_c = t_rdata[32*i +: 32];
            end
        end
    end

    // Next state: abort beats ack, ack beats timeout
    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE: if (req_c) nxt = dec_hit_c ? ST_WAIT : ST_RESP;
            ST_WAIT: begin
                if (abort_c)             nxt = ST_IDLE;
                else if (ack_c || tmo_c) nxt = ST_RESP;
            end
            ST_RESP: nxt = ST_IDLE;
            default: nxt = ST_IDLE;
        endcase
    end

    // Next values for all registered outputs and datapath state
    always_comb begin
        resp_err_c = ((state == ST_IDLE) && req_c && !dec_hit_c) ||
                     ((state == ST_WAIT) && !abort_c && !ack_c && tmo_c);
        sel_idx_c  = (state == ST_IDLE) ? dec_idx_c : idx_q;

        ack_d     = (nxt == ST_RESP);
        irq_d     = resp_err_c;
        rdata_d   = wbs_rdata;
        err_cnt_d = err_cnt;
        wait_d    = '0;
        adr_d     = t_adr;
        wdata_d   = t_wdata;
        sel_d     = t_sel;
        we_d      = t_we;
        idx_d     = idx_q;
        strobe_d  = '0;

        if (nxt == ST_RESP)
            rdata_d = resp_err_c ? ERR_DATA : tgt_rdata_c;
        if (resp_err_c && (err_cnt != '1))
            err_cnt_d = err_cnt + CNT_W'(1);
        if ((state == ST_WAIT) && (nxt == ST_WAIT))
            wait_d = wait_cnt + CNT_W'(1);
        if ((state == ST_IDLE) && req_c) begin
            adr_d   = wbs_adr[WIN_W-1:0];
            wdata_d = wbs_wdata;
            sel_d   = wbs_sel;
            we_d    = wbs_we;
            idx_d   = dec_idx_c;
        end
        for (int i = 0; i < NT; i++)
            strobe_d[i] = (nxt == ST_WAIT) && (sel_idx_c == IDX_W'(i));
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            idx_q     <= '0;
            wbs_ack   <= 1'b0;
            wbs_rdata <= '0;
            t_cyc     <= '0;
            t_stb     <= '0;
            t_we      <= 1'b0;
            t_adr     <= '0;
            t_wdata   <= '0;
            t_sel     <= '0;
            err_cnt   <= '0;
            err_irq   <= 1'b0;
        end else begin
            state     <= nxt;
            wait_cnt  <= wait_d;
            idx_q     <= idx_d;
            wbs_ack   <= ack_d;
            wbs_rdata <= rdata_d;
            t_cyc     <= strobe_d;
            t_stb     <= strobe_d;
            t_we      <= we_d;
            t_adr     <= adr_d;
            t_wdata   <= wdata_d;
            t_sel     <= sel_d;
            err_cnt   <= err_cnt_d;
            err_irq   <= irq_d;
        end
    end

endmodule

// File: tb/tb_fsic_wb_dispatch.sv
// Self-checking bench for fsic_wb_dispatch: directed table, randomized
// transactions against a transaction-level model, abort and reset sequences.
module tb_fsic_wb_dispatch;

    localparam int unsigned NT      = 4;
    localparam int unsigned TIMEOUT = 8;
    localparam logic [31:0] ERR_W   = 32'hDEAD_BEEF;

    logic              wb_clk = 1'b0;
    logic              wb_rst_n = 1'b0;
    logic              wbs_cyc = 1'b0, wbs_stb = 1'b0, wbs_we = 1'b0;
    logic [31:0]       wbs_adr = '0, wbs_wdata = '0;
    logic [3:0]        wbs_sel = '0;
    logic              wbs_ack;
    logic [31:0]       wbs_rdata;
    logic [NT-1:0]     t_cyc, t_stb;
    logic              t_we;
    logic [11:0]       t_adr;
    logic [31:0]       t_wdata;
    logic [3:0]        t_sel;
    logic [NT*32-1:0]  t_rdata = '0;
    logic [NT-1:0]     t_ack = '0;
    logic [7:0]        err_cnt;
    logic              err_irq;

    fsic_wb_dispatch #(.NT(NT), .TIMEOUT(TIMEOUT)) dut (
        .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
        .wbs_cyc(wbs_cyc), .wbs_stb(wbs_stb), .wbs_we(wbs_we),
        .wbs_adr(wbs_adr), .wbs_wdata(wbs_wdata), .wbs_sel(wbs_sel),
        .wbs_ack(wbs_ack), .wbs_rdata(wbs_rdata),
        .t_cyc(t_cyc), .t_stb(t_stb), .t_we(t_we), .t_adr(t_adr),
        .t_wdata(t_wdata), .t_sel(t_sel), .t_rdata(t_rdata), .t_ack(t_ack),
        .err_cnt(err_cnt), .err_irq(err_irq)
    );

    always #5 wb_clk = ~wb_clk;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    typedef struct {
        logic [31:0]   adr;
        logic          we;
        logic [31:0]   wdata;
        logic [3:0]    sel;
        int            delay;
        logic [31:0]   data;
        int            lat;
        int            stb_n;
        logic [31:0]   rd;
        logic          err;
        logic [NT-1:0] oh;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_zero(input string nm);
        chk({nm, ".wbs_ack"}, 32'(wbs_ack), 0);
        chk({nm, ".wbs_rdata"}, wbs_rdata, 0);
        chk({nm, ".t_cyc"}, 32'(t_cyc), 0);
        chk({nm, ".t_stb"}, 32'(t_stb), 0);
        chk({nm, ".t_we"}, 32'(t_we), 0);
        chk({nm, ".t_adr"}, 32'(t_adr), 0);
        chk({nm, ".t_wdata"}, t_wdata, 0);
        chk({nm, ".t_sel"}, 32'(t_sel), 0);
        chk({nm, ".err_cnt"}, 32'(err_cnt), 0);
        chk({nm, ".err_irq"}, 32'(err_irq), 0);
    endtask

    // Transaction-level expectation: hit/miss, ack delay versus the timeout budget
    function automatic void model(input logic [31:0] adr, input int delay, input logic [31:0] data,
                                  output int lat, output int stb_n, output logic [31:0] rd,
                                  output logic err, output logic [NT-1:0] oh);
        int  page;
        bit  hit;
        page = int'(adr[15:12]);
        hit  = (adr[31:16] == 16'h3000) && (page < NT);
        oh   = '0;
        if (!hit) begin
            lat = 1; stb_n = 0; rd = ERR_W; err = 1'b1;
        end else begin
            oh = NT'(1) << page;
            if (delay < TIMEOUT) begin
                stb_n = delay + 1; lat = delay + 2; rd = data; err = 1'b0;
            end else begin
                stb_n = TIMEOUT; lat = TIMEOUT + 1; rd = ERR_W; err = 1'b1;
            end
        end
    endfunction

    // Drives one upstream access and plays the addressed target; delay = stb cycles before ack
    task automatic do_txn(input logic [31:0] adr, input logic we, input logic [31:0] wdata,
                          input logic [3:0] sel, input int delay, input logic [31:0] data,
                          input bit noise, input int abort_k,
                          output int lat, output int stb_n, output logic [31:0] rd,
                          output int ack_n, output int irq_n, output logic [NT-1:0] seen_oh,
                          output logic shape_ok, output logic [NT-1:0] cyc_after);
        int            page;
        logic [NT-1:0] own;
        page = int'(adr[15:12]);
        own  = (page < NT) ? (NT'(1) << page) : '0;
        lat = 0; stb_n = 0; rd = '0; ack_n = 0; irq_n = 0;
        seen_oh = '0; shape_ok = 1'b1; cyc_after = '1;
        @(negedge wb_clk);
        wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = we;
        wbs_adr = adr; wbs_wdata = wdata; wbs_sel = sel;
        for (int k = 1; k <= 3 * TIMEOUT + 20; k++) begin
            @(negedge wb_clk);
            t_ack = noise ? (NT'($urandom) & ~own) : '0;
            for (int i = 0; i < NT; i++)
                t_rdata[32*i +: 32] = own[i] ? data : $urandom;
            if (t_stb != '0) begin
                stb_n++;
                seen_oh |= t_stb;
                if (t_cyc != t_stb || t_adr != adr[11:0] || t_we != we ||
                    t_wdata != wdata || t_sel != sel)
                    shape_ok = 1'b0;
                if (stb_n - 1 == delay) t_ack = t_ack | own;
            end
            if (err_irq) irq_n++;
            if (wbs_ack) begin
                ack_n++;
                if (lat == 0) begin lat = k; rd = wbs_rdata; end
                wbs_cyc = 1'b0; wbs_stb = 1'b0;
            end
            if (abort_k != 0 && k == abort_k) begin wbs_cyc = 1'b0; wbs_stb = 1'b0; end
            if (abort_k != 0 && k == abort_k + 1) cyc_after = t_cyc;
            if (lat != 0 && k == lat + 1) break;
            if (abort_k != 0 && k == abort_k + 4) break;
        end
        t_ack = '0; wbs_cyc = 1'b0; wbs_stb = 1'b0;
    endtask

    task automatic run(input string nm, input logic [31:0] adr, input logic we, input logic [31:0] wdata,
                       input logic [3:0] sel, input int delay, input logic [31:0] data, input bit noise,
                       input int e_lat, input int e_stb, input logic [31:0] e_rd, input logic e_err,
                       input logic [NT-1:0] e_oh);
        int lat, stb_n, ack_n, irq_n;
        logic [31:0] rd;
        logic [NT-1:0] oh, ca;
        logic shape_ok;
        do_txn(adr, we, wdata, sel, delay, data, noise, 0, lat, stb_n, rd, ack_n, irq_n, oh, shape_ok, ca);
        if (e_err && exp_cnt < 255) exp_cnt++;
        chk({nm, ".latency"}, 32'(lat), 32'(e_lat));
        chk({nm, ".stb_cycles"}, 32'(stb_n), 32'(e_stb));
        chk({nm, ".rdata"}, rd, e_rd);
        chk({nm, ".ack_pulses"}, 32'(ack_n), 1);
        chk({nm, ".irq_pulses"}, 32'(irq_n), 32'(e_err));
        chk({nm, ".target"}, 32'(oh), 32'(e_oh));
        if (e_stb > 0) chk({nm, ".fields"}, 32'(shape_ok), 1);
        chk({nm, ".err_cnt"}, 32'(err_cnt), 32'(exp_cnt));
    endtask

    initial begin
        int lat, stb_n, ack_n, irq_n;
        logic [31:0] rd;
        logic [NT-1:0] oh, ca;
        logic shape_ok, err;
        logic [31:0] adr, data;
        int delay;

        vecs[0] = '{32'h3000_2010, 1'b0, 32'h0, 4'hF, 3, 32'h1234_5678, 5, 4, 32'h1234_5678, 1'b0, 4'b0100};
        vecs[1] = '{32'h3000_0004, 1'b1, 32'hA5A5_0F0F, 4'b0011, 0, 32'h0, 2, 1, 32'h0, 1'b0, 4'b0001};
        vecs[2] = '{32'h3000_7000, 1'b0, 32'h0, 4'hF, 0, 32'h1111_1111, 1, 0, ERR_W, 1'b1, 4'b0000};
        vecs[3] = '{32'h3000_1FFC, 1'b0, 32'h0, 4'hF, 255, 32'h2222_2222, 9, 8, ERR_W, 1'b1, 4'b0010};
        vecs[4] = '{32'h3000_3ABC, 1'b0, 32'h0, 4'hF, 7, 32'hCAFE_F00D, 9, 8, 32'hCAFE_F00D, 1'b0, 4'b1000};
        vecs[5] = '{32'h2000_0000, 1'b1, 32'h5555_AAAA, 4'hF, 0, 32'h3333_3333, 1, 0, ERR_W, 1'b1, 4'b0000};
        vecs[6] = '{32'h3000_3000, 1'b1, 32'h0BAD_F00D, 4'b1000, 6, 32'h4444_4444, 8, 7, 32'h4444_4444, 1'b0, 4'b1000};
        vecs[7] = '{32'h3000_4000, 1'b0, 32'h0, 4'hF, 0, 32'h5555_5555, 1, 0, ERR_W, 1'b1, 4'b0000};

        repeat (2) @(negedge wb_clk);
        check_zero("reset");
        wb_rst_n = 1'b1;

        for (int v = 0; v < 8; v++)
            run($sformatf("vec%0d", v), vecs[v].adr, vecs[v].we, vecs[v].wdata, vecs[v].sel,
                vecs[v].delay, vecs[v].data, 1'b0, vecs[v].lat, vecs[v].stb_n, vecs[v].rd,
                vecs[v].err, vecs[v].oh);

        for (int r = 0; r < 40; r++) begin
            adr = {16'h3000, 4'($urandom_range(0, 5)), 12'($urandom)};
            if ($urandom_range(0, 5) == 0) adr[31:16] = 16'($urandom);
            delay = $urandom_range(0, TIMEOUT + 2);
            data  = $urandom;
            model(adr, delay, data, lat, stb_n, rd, err, oh);
            run($sformatf("rand%0d", r), adr, 1'($urandom), $urandom, 4'($urandom), delay, data,
                1'b1, lat, stb_n, rd, err, oh);
        end

        // Abort while waiting on a silent target
        do_txn(32'h3000_1020, 1'b1, 32'h1357_9BDF, 4'hF, 255, 32'h0, 1'b0, 2,
               lat, stb_n, rd, ack_n, irq_n, oh, shape_ok, ca);
        chk("abort.ack_pulses", 32'(ack_n), 0);
        chk("abort.t_cyc_after", 32'(ca), 0);
        chk("abort.irq_pulses", 32'(irq_n), 0);
        chk("abort.err_cnt", 32'(err_cnt), 32'(exp_cnt));

        // Abort in the same cycle the target acks
        do_txn(32'h3000_0100, 1'b0, 32'h0, 4'hF, 2, 32'h7777_7777, 1'b0, 3,
               lat, stb_n, rd, ack_n, irq_n, oh, shape_ok, ca);
        chk("abort_ack.ack_pulses", 32'(ack_n), 0);
        chk("abort_ack.t_cyc_after", 32'(ca), 0);
        chk("abort_ack.err_cnt", 32'(err_cnt), 32'(exp_cnt));
        run("after_abort", 32'h3000_2200, 1'b0, 32'h0, 4'hF, 1, 32'h600D_DA7A, 1'b0,
            3, 2, 32'h600D_DA7A, 1'b0, 4'b0100);

        // Asynchronous reset in the middle of WAIT
        @(negedge wb_clk);
        wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = 1'b1;
        wbs_adr = 32'h3000_1008; wbs_wdata = 32'hFEED_FACE; wbs_sel = 4'hF;
        repeat (3) @(negedge wb_clk);
        chk("rst_mid.pre_stb", 32'(t_stb), 32'h2);
        #2 wb_rst_n = 1'b0;
        #1 check_zero("rst_mid");
        wbs_cyc = 1'b0; wbs_stb = 1'b0; exp_cnt = 0;
        @(negedge wb_clk);
        wb_rst_n = 1'b1;
        repeat (3) @(negedge wb_clk);
        chk("rst_mid.no_ack", 32'(wbs_ack), 0);
        chk("rst_mid.cnt_cleared", 32'(err_cnt), 0);

        for (int m = 0; m < 300; m++)
            run("miss_burst", {16'h3000, 4'($urandom_range(4, 15)), 12'($urandom)}, 1'($urandom),
                $urandom, 4'hF, 0, 32'h0, 1'b1, 1, 0, ERR_W, 1'b1, '0);
        chk("saturate.err_cnt", 32'(err_cnt), 255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
